// File: rtl/lfsr_led_router.sv
// LFSR-timed LED router: a maximal-length XNOR LFSR produces a periodic tick that
// is prescaled into steps driving blink and chase patterns on N one-hot LED channels.
module lfsr_led_router #(
  parameter int SEL_W   = 2,
  parameter int LFSR_W  = 22,
  parameter int TAP_A   = 21,
  parameter int TAP_B   = 20,
  parameter int DEB_CYC = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic [1:0]          i_mode,
  input  logic [1:0]          i_rate,
  output logic [2**SEL_W-1:0] o_led,
  output logic                o_tick
);

  localparam int N     = 2**SEL_W;
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_CHASE = 2'b11
  } mode_e;

  mode_e             mode;
  logic [LFSR_W-1:0] lfsr;
  logic              tick;
  logic [1:0]        presc;
  logic [3:0]        rate_lim;
  logic              step;
  logic              phase;
  logic [SEL_W-1:0]  chase_idx;
  logic [SEL_W-1:0]  sel_meta;
  logic [SEL_W-1:0]  sel_sync;
  logic [SEL_W-1:0]  sel_prev;
  logic [SEL_W-1:0]  sel_act;
  logic [DEB_W-1:0]  deb_cnt;
  logic [DEB_W-1:0]  deb_run;
  logic [N-1:0]      led_nxt;

  assign mode = mode_e'(i_mode);
  assign tick = (lfsr == '0);

  // rate 3 gives a limit of 7, which the 2-bit prescaler never matches
  assign rate_lim = (4'd1 << i_rate) - 4'd1;
  assign step     = tick && ({2'b00, presc} == rate_lim);

  // Run length of the synchronised select, counting the current cycle
  assign deb_run = (sel_sync == sel_prev) ? deb_cnt + DEB_W'(1) : DEB_W'(1);

  always_comb begin
    led_nxt = '0;
    case (mode)
      MODE_OFF:   led_nxt = '0;
      MODE_SOLID: led_nxt[sel_act] = 1'b1;
      MODE_BLINK: led_nxt[sel_act] = phase;
      MODE_CHASE: led_nxt[chase_idx] = 1'b1;
      default:    led_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr      <= '0;
      presc     <= '0;
      phase     <= 1'b0;
      chase_idx <= '0;
      o_tick    <= 1'b0;
      o_led     <= '0;
    end else begin
      lfsr   <= {lfsr[LFSR_W-2:0], ~(lfsr[TAP_A] ^ lfsr[TAP_B])};
      o_tick <= tick;
      o_led  <= led_nxt;
      if (tick) begin
        presc <= step ? 2'd0 : presc + 2'd1;
      end
      if (step) begin
        phase <= ~phase;
        if (mode == MODE_CHASE) begin
          chase_idx <= chase_idx + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_meta <= '0;
      sel_sync <= '0;
      sel_prev <= '0;
      sel_act  <= '0;
      deb_cnt  <= '0;
    end else begin
      sel_meta <= i_sel;
      sel_sync <= sel_meta;
      sel_prev <= sel_sync;
      if (sel_sync == sel_act) begin
        deb_cnt <= '0;
      end else if (deb_run == DEB_MAX) begin
        sel_act <= sel_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_run;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_led_router.sv
// Directed bench for lfsr_led_router with a 4-bit LFSR (15-cycle tick period).
module tb_lfsr_led_router;

  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] i_sel;
  logic [1:0] i_mode;
  logic [1:0] i_rate;
  logic [3:0] o_led;
  logic       o_tick;

  int total = 0;
  int bad   = 0;

  lfsr_led_router #(
    .SEL_W  (2),
    .LFSR_W (4),
    .TAP_A  (3),
    .TAP_B  (2),
    .DEB_CYC(4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_sel  (i_sel),
    .i_mode (i_mode),
    .i_rate (i_rate),
    .o_led  (o_led),
    .o_tick (o_tick)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance n rising edges and settle 1ns past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Reset with the given inputs; the next rising edge is edge 1 after release
  task automatic apply_reset(input logic [1:0] mode, input logic [1:0] rate, input logic [1:0] sel);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_mode  = mode;
    i_rate  = rate;
    i_sel   = sel;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_mode  = 2'b01;
    i_rate  = 2'd0;
    i_sel   = 2'd0;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL reset_led got=%b exp=%b", o_led, 4'b0000); end
    total++;
    if (o_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=%b", o_tick, 1'b0); end
    i_rst_n = 1'b1;
    cyc(1);
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL reset_solid_e1 got=%b exp=%b", o_led, 4'b0001); end
  endtask

  task automatic test_blink;
    apply_reset(2'b10, 2'd0, 2'd0);
    cyc(1);  // edge 1: first tick and step
    total++;
    if (o_tick !== 1'b1) begin bad++; $display("FAIL blink_tick_e1 got=%b exp=%b", o_tick, 1'b1); end
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL blink_led_e1 got=%b exp=%b", o_led, 4'b0000); end
    cyc(1);  // edge 2
    total++;
    if (o_tick !== 1'b0) begin bad++; $display("FAIL blink_tick_e2 got=%b exp=%b", o_tick, 1'b0); end
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL blink_led_e2 got=%b exp=%b", o_led, 4'b0001); end
    cyc(13); // edge 15
    total++;
    if (o_tick !== 1'b0) begin bad++; $display("FAIL blink_tick_e15 got=%b exp=%b", o_tick, 1'b0); end
    cyc(1);  // edge 16
    total++;
    if (o_tick !== 1'b1) begin bad++; $display("FAIL blink_tick_e16 got=%b exp=%b", o_tick, 1'b1); end
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL blink_led_e16 got=%b exp=%b", o_led, 4'b0001); end
    cyc(1);  // edge 17
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL blink_led_e17 got=%b exp=%b", o_led, 4'b0000); end
    cyc(14); // edge 31
    total++;
    if (o_tick !== 1'b1) begin bad++; $display("FAIL blink_tick_e31 got=%b exp=%b", o_tick, 1'b1); end
    cyc(1);  // edge 32
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL blink_led_e32 got=%b exp=%b", o_led, 4'b0001); end
  endtask

  task automatic test_rate;
    apply_reset(2'b10, 2'd2, 2'd0);
    cyc(46); // edge 46: prescaler reaches 3 -> first step
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL rate2_led_e46 got=%b exp=%b", o_led, 4'b0000); end
    cyc(1);
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL rate2_led_e47 got=%b exp=%b", o_led, 4'b0001); end
    cyc(59); // edge 106
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL rate2_led_e106 got=%b exp=%b", o_led, 4'b0001); end
    cyc(1);  // edge 107
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL rate2_led_e107 got=%b exp=%b", o_led, 4'b0000); end
    cyc(30); // edge 137: prescaler is 2
    i_rate = 2'd0;
    cyc(30); // edge 167: ticks at 151,166 wrap 2->3->0 without stepping
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL rate_drop_e167 got=%b exp=%b", o_led, 4'b0000); end
    cyc(14); // edge 181
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL rate_drop_e181 got=%b exp=%b", o_led, 4'b0000); end
    cyc(1);
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL rate_drop_e182 got=%b exp=%b", o_led, 4'b0001); end
    cyc(14); // edge 196
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL rate_drop_e196 got=%b exp=%b", o_led, 4'b0001); end
    cyc(1);
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL rate_drop_e197 got=%b exp=%b", o_led, 4'b0000); end
  endtask

  task automatic test_select;
    apply_reset(2'b01, 2'd0, 2'd0);
    cyc(1);
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL sel_e1 got=%b exp=%b", o_led, 4'b0001); end
    cyc(4);  // edge 5
    i_sel = 2'd2;
    cyc(6);  // edge 11
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL sel_before_e11 got=%b exp=%b", o_led, 4'b0001); end
    cyc(1);  // edge 12 = 2 sync + 4 debounce + 1 output
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL sel_after_e12 got=%b exp=%b", o_led, 4'b0100); end
    cyc(3);
    i_sel = 2'd1;
    cyc(3);
    i_sel = 2'd2;
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL glitch_e18 got=%b exp=%b", o_led, 4'b0100); end
    cyc(4);
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL glitch_e22 got=%b exp=%b", o_led, 4'b0100); end
    cyc(8);
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL glitch_e30 got=%b exp=%b", o_led, 4'b0100); end
    i_mode = 2'b00;
    #1;
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL off_registered got=%b exp=%b", o_led, 4'b0100); end
    cyc(1);
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL off_led got=%b exp=%b", o_led, 4'b0000); end
    i_mode = 2'b01;
    cyc(1);
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL solid_again got=%b exp=%b", o_led, 4'b0100); end
  endtask

  task automatic test_mode_switch;
    apply_reset(2'b10, 2'd0, 2'd0);
    cyc(2);  // edge 2: phase=1 shown
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL msw_blink_e2 got=%b exp=%b", o_led, 4'b0001); end
    i_mode = 2'b11;
    cyc(1);  // edge 3: chase from held index 0
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL msw_chase_e3 got=%b exp=%b", o_led, 4'b0001); end
    cyc(14); // edge 17: step at 16 -> index 1, phase 0
    total++;
    if (o_led !== 4'b0010) begin bad++; $display("FAIL msw_chase_e17 got=%b exp=%b", o_led, 4'b0010); end
    i_mode = 2'b10;
    cyc(1);
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL msw_blink_e18 got=%b exp=%b", o_led, 4'b0000); end
    cyc(14); // edge 32: step at 31 -> phase 1, index held
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL msw_blink_e32 got=%b exp=%b", o_led, 4'b0001); end
    i_mode = 2'b11;
    cyc(1);
    total++;
    if (o_led !== 4'b0010) begin bad++; $display("FAIL msw_chase_held got=%b exp=%b", o_led, 4'b0010); end
  endtask

  task automatic test_chase_reset;
    apply_reset(2'b11, 2'd0, 2'd0);
    cyc(1);
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL chase_e1 got=%b exp=%b", o_led, 4'b0001); end
    cyc(1);
    total++;
    if (o_led !== 4'b0010) begin bad++; $display("FAIL chase_e2 got=%b exp=%b", o_led, 4'b0010); end
    cyc(14);
    total++;
    if (o_led !== 4'b0010) begin bad++; $display("FAIL chase_e16 got=%b exp=%b", o_led, 4'b0010); end
    cyc(1);
    total++;
    if (o_led !== 4'b0100) begin bad++; $display("FAIL chase_e17 got=%b exp=%b", o_led, 4'b0100); end
    cyc(15);
    total++;
    if (o_led !== 4'b1000) begin bad++; $display("FAIL chase_e32 got=%b exp=%b", o_led, 4'b1000); end
    cyc(3);
    #2;
    i_rst_n = 1'b0;  // mid-cycle, no clock edge involved
    #1;
    total++;
    if (o_led !== 4'b0000) begin bad++; $display("FAIL async_rst_led got=%b exp=%b", o_led, 4'b0000); end
    total++;
    if (o_tick !== 1'b0) begin bad++; $display("FAIL async_rst_tick got=%b exp=%b", o_tick, 1'b0); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(1);
    total++;
    if (o_tick !== 1'b1) begin bad++; $display("FAIL restart_tick_e1 got=%b exp=%b", o_tick, 1'b1); end
    total++;
    if (o_led !== 4'b0001) begin bad++; $display("FAIL restart_led_e1 got=%b exp=%b", o_led, 4'b0001); end
    cyc(1);
    total++;
    if (o_tick !== 1'b0) begin bad++; $display("FAIL restart_tick_e2 got=%b exp=%b", o_tick, 1'b0); end
    total++;
    if (o_led !== 4'b0010) begin bad++; $display("FAIL restart_led_e2 got=%b exp=%b", o_led, 4'b0010); end
    cyc(13);
    total++;
    if (o_tick !== 1'b0) begin bad++; $display("FAIL restart_tick_e15 got=%b exp=%b", o_tick, 1'b0); end
    cyc(1);
    total++;
    if (o_tick !== 1'b1) begin bad++; $display("FAIL restart_tick_e16 got=%b exp=%b", o_tick, 1'b1); end
  endtask

  task automatic test_random_onehot;
    apply_reset(2'b00, 2'd0, 2'd0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      total++;
      if ($countones(o_led) > 1) begin
        bad++;
        $display("FAIL onehot cycle=%0d got=%b exp=at_most_one_bit", i, o_led);
      end
      i_sel  = 2'($urandom_range(0, 3));
      i_mode = 2'($urandom_range(0, 3));
      i_rate = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_sel   = 2'd0;
    i_mode  = 2'b00;
    i_rate  = 2'd0;
    test_reset();
    test_blink();
    test_rate();
    test_select();
    test_mode_switch();
    test_chase_reset();
    test_random_onehot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
